// File: rtl/match_sequencer_if.sv
// Signal bundle between the match sequencer, the player inputs and the game datapath.
// The sequencer uses the master modport; the surrounding logic (or a bench) uses slave.
// Inputs are plain levels/pulses sampled on clk; outputs are registered and valid every cycle.
interface match_sequencer_if;
    logic       frame_tick;
    logic       start;
    logic       pause;
    logic       miss_left;
    logic       miss_right;
    logic       ball_en;
    logic       ball_reset;
    logic       serve_dir;
    logic [4:0] score1;
    logic [4:0] score2;
    logic [1:0] winner;
    logic [2:0] state;

    modport master (
        input  frame_tick, start, pause, miss_left, miss_right,
        output ball_en, ball_reset, serve_dir, score1, score2, winner, state
    );

    modport slave (
        output frame_tick, start, pause, miss_left, miss_right,
        input  ball_en, ball_reset, serve_dir, score1, score2, winner, state
    );
endinterface

// File: rtl/match_sequencer.sv
// Match-level FSM for the ball/paddle game: owns scores, serve hold time,
// pause and game-over. All timing is counted in frame_tick pulses.
module match_sequencer #(
    parameter int WIN_SCORE    = 11,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90
) (
    input  logic                clk,
    input  logic                rst,
    match_sequencer_if.master   bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SERVE  = 3'd1,
        PLAY   = 3'd2,
        PAUSED = 3'd3,
        POINT  = 3'd4,
        OVER   = 3'd5
    } state_t;

    localparam logic [4:0] WIN_VAL    = 5'(WIN_SCORE);
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);

    state_t     state_r;
    logic [7:0] frame_cnt;
    logic       start_q;
    logic       pause_q;
    logic       ball_en_r;
    logic       ball_reset_r;
    logic       serve_dir_r;
    logic [4:0] score1_r;
    logic [4:0] score2_r;
    logic [1:0] winner_r;

    logic start_rise;
    logic pause_rise;

    // Button edge detectors; the edge registers reset high so a held button is not a press.
    assign start_rise = bus.start & ~start_q;
    assign pause_rise = bus.pause & ~pause_q;

    assign bus.ball_en    = ball_en_r;
    assign bus.ball_reset = ball_reset_r;
    assign bus.serve_dir  = serve_dir_r;
    assign bus.score1     = score1_r;
    assign bus.score2     = score2_r;
    assign bus.winner     = winner_r;
    assign bus.state      = state_r;

    // Match FSM with registered outputs; ball_reset is a one-cycle pulse by default-low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            frame_cnt    <= 8'd0;
            start_q      <= 1'b1;
            pause_q      <= 1'b1;
            ball_en_r    <= 1'b0;
            ball_reset_r <= 1'b0;
            serve_dir_r  <= 1'b0;
            score1_r     <= 5'd0;
            score2_r     <= 5'd0;
            winner_r     <= 2'b00;
        end else begin
            start_q      <= bus.start;
            pause_q      <= bus.pause;
            ball_reset_r <= 1'b0;

            case (state_r)
                IDLE, OVER: begin
                    ball_en_r <= 1'b0;
                    if (start_rise) begin
                        score1_r     <= 5'd0;
                        score2_r     <= 5'd0;
                        winner_r     <= 2'b00;
                        serve_dir_r  <= 1'b0;
                        ball_reset_r <= 1'b1;
                        frame_cnt    <= 8'd0;
                        state_r      <= SERVE;
                    end
                end

                SERVE: begin
                    ball_en_r <= 1'b0;
                    if (bus.frame_tick) begin
                        if (frame_cnt == SERVE_LAST) begin
                            frame_cnt <= 8'd0;
                            ball_en_r <= 1'b1;
                            state_r   <= PLAY;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end

                PLAY: begin
                    ball_en_r <= 1'b1;
                    // Left miss outranks right miss, and any miss outranks pause.
                    if (bus.miss_left) begin
                        score2_r    <= score2_r + 5'd1;
                        serve_dir_r <= 1'b0;
                        ball_en_r   <= 1'b0;
                        frame_cnt   <= 8'd0;
                        state_r     <= POINT;
                    end else if (bus.miss_right) begin
                        score1_r    <= score1_r + 5'd1;
                        serve_dir_r <= 1'b1;
                        ball_en_r   <= 1'b0;
                        frame_cnt   <= 8'd0;
                        state_r     <= POINT;
                    end else if (pause_rise) begin
                        ball_en_r <= 1'b0;
                        state_r   <= PAUSED;
                    end
                end

                PAUSED: begin
                    ball_en_r <= 1'b0;
                    if (pause_rise) begin
                        ball_en_r <= 1'b1;
                        state_r   <= PLAY;
                    end
                end

                POINT: begin
                    ball_en_r <= 1'b0;
                    if (bus.frame_tick) begin
                        if (frame_cnt == POINT_LAST) begin
                            frame_cnt <= 8'd0;
                            if (score1_r == WIN_VAL) begin
                                winner_r <= 2'b01;
                                state_r  <= OVER;
                            end else if (score2_r == WIN_VAL) begin
                                winner_r <= 2'b10;
                                state_r  <= OVER;
                            end else begin
                                ball_reset_r <= 1'b1;
                                state_r      <= SERVE;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end

                default: begin
                    ball_en_r <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer with short parameters (WIN=2, SERVE=4, POINT=5).
module tb_match_sequencer;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    match_sequencer_if bus ();

    match_sequencer #(
        .WIN_SCORE    (2),
        .SERVE_FRAMES (4),
        .POINT_FRAMES (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock: 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock: inputs change and outputs are sampled 1 unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // n frame ticks, each a one-cycle pulse followed by an idle cycle.
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frame_tick = 1'b1;
            cyc();
            bus.frame_tick = 1'b0;
            cyc();
        end
    endtask

    task automatic press_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic press_pause();
        bus.pause = 1'b1;
        cyc();
        bus.pause = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Directed scenario: reset, serve, points, pause, ties, win, restart, async reset.
    initial begin
        n_cmp = 0;
        n_err = 0;
        rst            = 1'b0;
        bus.frame_tick = 1'b0;
        bus.start      = 1'b1;
        bus.pause      = 1'b0;
        bus.miss_left  = 1'b0;
        bus.miss_right = 1'b0;

        // Reset with start held high.
        cyc();
        cyc();
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_ball_en", 32'(bus.ball_en), 32'd0);
        check("rst_ball_reset", 32'(bus.ball_reset), 32'd0);
        check("rst_serve_dir", 32'(bus.serve_dir), 32'd0);
        check("rst_score1", 32'(bus.score1), 32'd0);
        check("rst_score2", 32'(bus.score2), 32'd0);
        check("rst_winner", 32'(bus.winner), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("held_start_state", 32'(bus.state), 32'd0);
            check("held_start_no_reset", 32'(bus.ball_reset), 32'd0);
        end

        // Release and press start: one-cycle ball_reset and SERVE.
        bus.start = 1'b0;
        cyc();
        press_start();
        check("start_state", 32'(bus.state), 32'd1);
        check("start_ball_reset", 32'(bus.ball_reset), 32'd1);
        check("start_score1", 32'(bus.score1), 32'd0);
        cyc();
        check("start_reset_pulse_end", 32'(bus.ball_reset), 32'd0);

        // Pause in SERVE is ignored.
        press_pause();
        check("serve_pause_ignored", 32'(bus.state), 32'd1);

        // Three ticks are not enough; the fourth releases the ball.
        frames(3);
        check("serve_3_ball_en", 32'(bus.ball_en), 32'd0);
        check("serve_3_state", 32'(bus.state), 32'd1);
        bus.frame_tick = 1'b1;
        cyc();
        bus.frame_tick = 1'b0;
        check("serve_4_ball_en", 32'(bus.ball_en), 32'd1);
        check("serve_4_state", 32'(bus.state), 32'd2);
        cyc();

        // Right miss: point to player 1.
        bus.miss_right = 1'b1;
        cyc();
        bus.miss_right = 1'b0;
        check("mr_score1", 32'(bus.score1), 32'd1);
        check("mr_serve_dir", 32'(bus.serve_dir), 32'd1);
        check("mr_ball_en", 32'(bus.ball_en), 32'd0);
        check("mr_state", 32'(bus.state), 32'd4);
        frames(4);
        check("point_4_state", 32'(bus.state), 32'd4);
        check("point_4_no_reset", 32'(bus.ball_reset), 32'd0);
        bus.frame_tick = 1'b1;
        cyc();
        bus.frame_tick = 1'b0;
        check("point_5_state", 32'(bus.state), 32'd1);
        check("point_5_ball_reset", 32'(bus.ball_reset), 32'd1);
        cyc();
        check("point_5_pulse_end", 32'(bus.ball_reset), 32'd0);

        // Back to PLAY, then pause / ignored miss / resume.
        frames(4);
        check("serve2_state", 32'(bus.state), 32'd2);
        press_pause();
        check("pause_state", 32'(bus.state), 32'd3);
        check("pause_ball_en", 32'(bus.ball_en), 32'd0);
        bus.miss_left = 1'b1;
        cyc();
        bus.miss_left = 1'b0;
        frames(2);
        check("paused_miss_state", 32'(bus.state), 32'd3);
        check("paused_miss_score2", 32'(bus.score2), 32'd0);
        press_pause();
        check("resume_state", 32'(bus.state), 32'd2);
        check("resume_ball_en", 32'(bus.ball_en), 32'd1);
        cyc();

        // Both misses plus pause press together: left miss wins, pause loses.
        bus.miss_left  = 1'b1;
        bus.miss_right = 1'b1;
        bus.pause      = 1'b1;
        cyc();
        bus.miss_left  = 1'b0;
        bus.miss_right = 1'b0;
        bus.pause      = 1'b0;
        check("both_state", 32'(bus.state), 32'd4);
        check("both_score2", 32'(bus.score2), 32'd1);
        check("both_score1", 32'(bus.score1), 32'd1);
        check("both_serve_dir", 32'(bus.serve_dir), 32'd0);

        // Nobody at 2 yet: back to SERVE, then PLAY.
        frames(5);
        check("nowin_state", 32'(bus.state), 32'd1);
        frames(4);
        check("play3_state", 32'(bus.state), 32'd2);

        // Second left miss: player 2 reaches WIN_SCORE and wins after POINT.
        bus.miss_left = 1'b1;
        cyc();
        bus.miss_left = 1'b0;
        check("ml2_score2", 32'(bus.score2), 32'd2);
        frames(5);
        check("over_state", 32'(bus.state), 32'd5);
        check("over_winner", 32'(bus.winner), 32'd2);
        check("over_score2", 32'(bus.score2), 32'd2);
        check("over_no_reset", 32'(bus.ball_reset), 32'd0);
        check("over_ball_en", 32'(bus.ball_en), 32'd0);

        // Restart from OVER.
        press_start();
        check("restart_state", 32'(bus.state), 32'd1);
        check("restart_score1", 32'(bus.score1), 32'd0);
        check("restart_score2", 32'(bus.score2), 32'd0);
        check("restart_winner", 32'(bus.winner), 32'd0);
        check("restart_ball_reset", 32'(bus.ball_reset), 32'd1);
        frames(4);
        check("restart_play_ball_en", 32'(bus.ball_en), 32'd1);

        // Async reset mid-PLAY, between clock edges.
        #2;
        rst = 1'b0;
        #1;
        check("async_ball_en", 32'(bus.ball_en), 32'd0);
        check("async_state", 32'(bus.state), 32'd0);
        cyc();
        rst = 1'b1;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
